// File: rtl/maf_cascade_mc_if.sv
// rtl/maf_cascade_mc_if.sv - sample/strobe bundle between the filter and its producer/consumer
//
// Purpose: groups the frame tick, packed channel samples, bypass control and the
//          filtered result/strobes of maf_cascade_mc.
// Signals:
//   i_enable  (master->slave) sample tick level, 0->1 starts one frame
//   i_xn      (master->slave) packed samples, channel c at [c*NB_SAMPLE +: NB_SAMPLE]
//   i_bypass  (master->slave) 1 = pass captured samples through unfiltered
//   o_signal  (slave->master) packed filtered outputs, same packing as i_xn
//   o_valid   (slave->master) one-cycle pulse when o_signal updates
//   o_overrun (slave->master) one-cycle pulse when a tick is dropped
interface maf_cascade_mc_if #(
    parameter int NB_SAMPLE = 8,
    parameter int NCH       = 3
);
    logic                       i_enable;
    logic [NCH*NB_SAMPLE-1:0]   i_xn;
    logic                       i_bypass;
    logic [NCH*NB_SAMPLE-1:0]   o_signal;
    logic                       o_valid;
    logic                       o_overrun;

    modport master (
        output i_enable, i_xn, i_bypass,
        input  o_signal, o_valid, o_overrun
    );

    modport slave (
        input  i_enable, i_xn, i_bypass,
        output o_signal, o_valid, o_overrun
    );
endinterface

// File: rtl/maf_cascade_mc.sv
// rtl/maf_cascade_mc.sv - multi-channel cascaded moving-average filter with compensation gain
//
// Purpose: filters NCH time-multiplexed channels through a length-MAF1 and then a
//          length-MAF2 recursive moving average followed by a Q.14 gain. One frame
//          (IDLE, 3 cycles per channel, DONE) is run per rising edge of i_enable.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-low
//   bus  maf_cascade_mc_if.slave: i_enable, i_xn, i_bypass in; o_signal, o_valid,
//        o_overrun out
module maf_cascade_mc #(
    parameter int NB_SAMPLE = 8,
    parameter int NCH       = 3,
    parameter int MAF1      = 20,
    parameter int MAF2      = 12,
    parameter int NB_PTR1   = 5,
    parameter int NB_PTR2   = 4,
    parameter int NB_COEFF  = 16,
    parameter int N1        = 1638,
    parameter int N2        = 2731,
    parameter int CF        = 16384
) (
    input  logic              clk,
    input  logic              rst,
    maf_cascade_mc_if.slave   bus
);

    localparam int NB_A1   = NB_SAMPLE + NB_PTR1;
    localparam int NB_A2   = NB_SAMPLE + NB_PTR2;
    localparam int NB_CH   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NB_WIDE = 48;

    // Coefficients are unsigned; zero-extending into the wide signed domain keeps
    // every product signed and full width.
    localparam logic [NB_COEFF-1:0]       C_N1 = NB_COEFF'(N1);
    localparam logic [NB_COEFF-1:0]       C_N2 = NB_COEFF'(N2);
    localparam logic [NB_COEFF-1:0]       C_CF = NB_COEFF'(CF);
    localparam logic signed [NB_WIDE-1:0] W_N1 = NB_WIDE'(C_N1);
    localparam logic signed [NB_WIDE-1:0] W_N2 = NB_WIDE'(C_N2);
    localparam logic signed [NB_WIDE-1:0] W_CF = NB_WIDE'(C_CF);
    localparam logic signed [NB_WIDE-1:0] SAT_HI = NB_WIDE'((1 <<< (NB_SAMPLE - 1)) - 1);
    localparam logic signed [NB_WIDE-1:0] SAT_LO = -SAT_HI - NB_WIDE'(1);

    typedef enum logic [2:0] {ST_IDLE, ST_S1, ST_S2, ST_S3, ST_DONE} state_t;

    function automatic logic signed [NB_SAMPLE-1:0] f_sat(input logic signed [NB_WIDE-1:0] v);
        logic signed [NB_WIDE-1:0] c;
        if (v > SAT_HI)      c = SAT_HI;
        else if (v < SAT_LO) c = SAT_LO;
        else                 c = v;
        return NB_SAMPLE'(c);
    endfunction

    state_t                        r_state;
    logic                          r_en_q;
    logic                          r_en_qq;
    logic [NB_CH-1:0]              r_ch;
    logic [NCH*NB_SAMPLE-1:0]      r_xin;
    logic                          r_bypass;
    logic [NB_PTR1-1:0]            r_p1;
    logic [NB_PTR2-1:0]            r_p2;
    logic signed [NB_A1-1:0]       r_acc1 [NCH];
    logic signed [NB_A2-1:0]       r_acc2 [NCH];
    logic signed [NB_SAMPLE-1:0]   r_buf1 [NCH][MAF1];
    logic signed [NB_SAMPLE-1:0]   r_buf2 [NCH][MAF2];
    logic signed [NB_SAMPLE-1:0]   r_res  [NCH];
    logic [NCH*NB_SAMPLE-1:0]      r_signal;
    logic                          r_valid;
    logic                          r_overrun;

    logic                          w_rise;
    logic signed [NB_SAMPLE-1:0]   w_x;
    logic signed [NB_WIDE-1:0]     w_acc1_sum;
    logic signed [NB_WIDE-1:0]     w_prod1;
    logic signed [NB_SAMPLE-1:0]   w_y1;
    logic signed [NB_WIDE-1:0]     w_acc2_sum;
    logic signed [NB_WIDE-1:0]     w_prod2;
    logic signed [NB_SAMPLE-1:0]   w_y2;
    logic signed [NB_WIDE-1:0]     w_prod3;
    logic signed [NB_SAMPLE-1:0]   w_y3;

    assign w_rise = r_en_q & ~r_en_qq;
    assign w_x    = $signed(r_xin[r_ch*NB_SAMPLE +: NB_SAMPLE]);

    // Stage 1 running sum: add the new sample, drop the one written MAF1 frames ago.
    assign w_acc1_sum = NB_WIDE'(r_acc1[r_ch]) + NB_WIDE'(w_x) - NB_WIDE'(r_buf1[r_ch][r_p1]);
    // S2 and S3 read the accumulators already updated in the previous cycle.
    assign w_prod1    = NB_WIDE'(r_acc1[r_ch]) * W_N1;
    assign w_y1       = f_sat(w_prod1 >>> 15);
    assign w_acc2_sum = NB_WIDE'(r_acc2[r_ch]) + NB_WIDE'(w_y1) - NB_WIDE'(r_buf2[r_ch][r_p2]);
    assign w_prod2    = NB_WIDE'(r_acc2[r_ch]) * W_N2;
    assign w_y2       = f_sat(w_prod2 >>> 15);
    assign w_prod3    = NB_WIDE'(w_y2) * W_CF;
    assign w_y3       = f_sat(w_prod3 >>> 14);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_en_q    <= 1'b0;
            r_en_qq   <= 1'b0;
            r_ch      <= '0;
            r_xin     <= '0;
            r_bypass  <= 1'b0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_signal  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_acc1[c] <= '0;
                r_acc2[c] <= '0;
                r_res[c]  <= '0;
                for (int i = 0; i < MAF1; i++) r_buf1[c][i] <= '0;
                for (int i = 0; i < MAF2; i++) r_buf2[c][i] <= '0;
            end
        end else begin
            r_en_q    <= bus.i_enable;
            r_en_qq   <= r_en_q;
            r_valid   <= 1'b0;
            // A tick arriving mid-frame is dropped, never queued.
            r_overrun <= w_rise && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_xin    <= bus.i_xn;
                        r_bypass <= bus.i_bypass;
                        r_ch     <= '0;
                        r_state  <= ST_S1;
                    end
                end
                ST_S1: begin
                    r_acc1[r_ch]       <= NB_A1'(w_acc1_sum);
                    r_buf1[r_ch][r_p1] <= w_x;
                    r_state            <= ST_S2;
                end
                ST_S2: begin
                    r_acc2[r_ch]       <= NB_A2'(w_acc2_sum);
                    r_buf2[r_ch][r_p2] <= w_y1;
                    r_state            <= ST_S3;
                end
                ST_S3: begin
                    // Filter state advances even in bypass so leaving bypass is seamless.
                    r_res[r_ch] <= r_bypass ? w_x : w_y3;
                    if (r_ch == NB_CH'(NCH - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= ST_S1;
                    end
                end
                ST_DONE: begin
                    for (int c = 0; c < NCH; c++) r_signal[c*NB_SAMPLE +: NB_SAMPLE] <= r_res[c];
                    r_valid <= 1'b1;
                    r_p1    <= (r_p1 == NB_PTR1'(MAF1 - 1)) ? '0 : r_p1 + 1'b1;
                    r_p2    <= (r_p2 == NB_PTR2'(MAF2 - 1)) ? '0 : r_p2 + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_signal  = r_signal;
    assign bus.o_valid   = r_valid;
    assign bus.o_overrun = r_overrun;

endmodule

// File: tb/tb_maf_cascade_mc.sv
// tb/tb_maf_cascade_mc.sv - scoreboard bench for maf_cascade_mc (unity and 18500 gain instances)
module tb_maf_cascade_mc;

    localparam int NB_SAMPLE = 8;
    localparam int NCH       = 3;
    localparam int MAF1      = 20;
    localparam int MAF2      = 12;
    localparam int N1        = 1638;
    localparam int N2        = 2731;
    localparam int CF_A      = 16384;
    localparam int CF_B      = 18500;
    localparam int W         = NCH * NB_SAMPLE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maf_cascade_mc_if #(.NB_SAMPLE(NB_SAMPLE), .NCH(NCH)) if0 ();
    maf_cascade_mc_if #(.NB_SAMPLE(NB_SAMPLE), .NCH(NCH)) if1 ();

    maf_cascade_mc u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    maf_cascade_mc #(.CF(CF_B)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_vec = 0;
    int n_miss = 0;
    int n_valid0 = 0, n_valid1 = 0, n_ovr0 = 0, n_ovr1 = 0;
    logic [W-1:0] last0, last1, last_exp0, tmp0, tmp1;
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];

    int m_buf1 [2][NCH][MAF1];
    int m_buf2 [2][NCH][MAF2];
    int m_acc1 [2][NCH];
    int m_acc2 [2][NCH];
    int m_p1 [2];
    int m_p2 [2];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sv(input logic [W-1:0] w, input int c);
        logic signed [NB_SAMPLE-1:0] s;
        s = w[c*NB_SAMPLE +: NB_SAMPLE];
        return int'(s);
    endfunction

    function automatic logic [W-1:0] pk(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic longint fdiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clampv(input longint v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_p1[k] = 0;
            m_p2[k] = 0;
            for (int c = 0; c < NCH; c++) begin
                m_acc1[k][c] = 0;
                m_acc2[k][c] = 0;
                for (int i = 0; i < MAF1; i++) m_buf1[k][c][i] = 0;
                for (int i = 0; i < MAF2; i++) m_buf2[k][c][i] = 0;
            end
        end
    endtask

    task automatic model_frame(input int k, input logic [W-1:0] xn, input logic byp, output logic [W-1:0] y);
        int cfv;
        cfv = (k == 0) ? CF_A : CF_B;
        y = '0;
        for (int c = 0; c < NCH; c++) begin
            int x, y1, y2, y3;
            x = sv(xn, c);
            m_acc1[k][c] = m_acc1[k][c] + x - m_buf1[k][c][m_p1[k]];
            m_buf1[k][c][m_p1[k]] = x;
            y1 = clampv(fdiv(longint'(m_acc1[k][c]) * N1, 32768));
            m_acc2[k][c] = m_acc2[k][c] + y1 - m_buf2[k][c][m_p2[k]];
            m_buf2[k][c][m_p2[k]] = y1;
            y2 = clampv(fdiv(longint'(m_acc2[k][c]) * N2, 32768));
            y3 = clampv(fdiv(longint'(y2) * cfv, 16384));
            y[c*NB_SAMPLE +: NB_SAMPLE] = byp ? 8'(x) : 8'(y3);
        end
        m_p1[k] = (m_p1[k] + 1) % MAF1;
        m_p2[k] = (m_p2[k] + 1) % MAF2;
    endtask

    task automatic drive(input logic en, input logic [W-1:0] xn, input logic byp);
        if0.i_enable = en; if0.i_xn = xn; if0.i_bypass = byp;
        if1.i_enable = en; if1.i_xn = xn; if1.i_bypass = byp;
    endtask

    // Outputs are sampled 1 ns after the rising edge and scored against the queues.
    always @(posedge clk) begin
        #1;
        if (if0.o_valid === 1'b1) begin
            n_valid0++;
            last0 = if0.o_signal;
            if (q0.size() == 0) chk("unexpected_valid0", 1, 0);
            else begin tmp0 = q0.pop_front(); chk("out0", if0.o_signal, tmp0); end
        end
        if (if1.o_valid === 1'b1) begin
            n_valid1++;
            last1 = if1.o_signal;
            if (q1.size() == 0) chk("unexpected_valid1", 1, 0);
            else begin tmp1 = q1.pop_front(); chk("out1", if1.o_signal, tmp1); end
        end
        if (if0.o_overrun === 1'b1) n_ovr0++;
        if (if1.o_overrun === 1'b1) n_ovr1++;
    end

    task automatic tick(input logic [W-1:0] xn, input logic byp);
        logic [W-1:0] e0, e1;
        int v0, lat;
        model_frame(0, xn, byp, e0);
        model_frame(1, xn, byp, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        last_exp0 = e0;
        v0 = n_valid0;
        @(negedge clk);
        drive(1'b1, xn, byp);
        lat = 0;
        while (n_valid0 == v0 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 3) drive(1'b0, xn, byp);
        end
        drive(1'b0, xn, byp);
        chk("latency", lat, 12);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        q0.delete();
        q1.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nz_obs, nz_exp, v0, o0, o1;
        logic [W-1:0] a_x, b_x;
        drive(1'b0, '0, 1'b0);
        model_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_signal0", if0.o_signal, 0);
        chk("rst_valid0", if0.o_valid, 0);
        chk("rst_overrun0", if0.o_overrun, 0);
        chk("rst_signal1", if1.o_signal, 0);
        rst = 1'b1;
        @(negedge clk);

        // DC 64 on ch0 only
        for (int i = 1; i <= 40; i++) begin
            tick(pk(64, 0, 0), 1'b0);
            if (i >= 31) chk("dc64_ch0", sv(last0, 0), 63);
        end
        chk("dc64_ch1", sv(last0, 1), 0);
        chk("dc64_ch2", sv(last0, 2), 0);

        // Saturation at both rails
        do_reset();
        for (int i = 0; i < 40; i++) tick(pk(127, 127, 127), 1'b0);
        for (int c = 0; c < NCH; c++) chk("sat_hi_gain", sv(last1, c), 127);
        chk("dc127_unity", sv(last0, 0), 126);
        for (int i = 0; i < 40; i++) tick(pk(-128, -128, -128), 1'b0);
        for (int c = 0; c < NCH; c++) chk("sat_lo_gain", sv(last1, c), -128);
        chk("sat_lo_unity", sv(last0, 2), -128);

        // Impulse on ch1
        do_reset();
        nz_obs = 0;
        nz_exp = 0;
        for (int i = 1; i <= 40; i++) begin
            tick((i == 1) ? pk(0, 100, 0) : pk(0, 0, 0), 1'b0);
            if (sv(last0, 1) != 0) nz_obs++;
            if (sv(last_exp0, 1) != 0) nz_exp++;
            if (i > MAF1 + MAF2 - 1) chk("impulse_tail", sv(last0, 1), 0);
        end
        chk("impulse_len", nz_obs, nz_exp);
        chk("impulse_span", (nz_obs > 0 && nz_obs <= MAF1 + MAF2 - 1), 1);
        chk("impulse_ch0", sv(last0, 0), 0);

        // Bypass, then back to filtering with a settled state
        do_reset();
        tick(pk(50, 0, -37), 1'b1);
        chk("bypass_ch2", sv(last0, 2), -37);
        chk("bypass_ch0", sv(last0, 0), 50);
        for (int i = 0; i < 39; i++) tick(pk(50, 0, -37), 1'b1);
        tick(pk(50, 0, -37), 1'b0);
        chk("unbypass_ch0", sv(last0, 0), 49);
        chk("unbypass_ch2", sv(last0, 2), -38);

        // Two rises 4 cycles apart: second must be dropped
        a_x = pk(10, 20, 30);
        b_x = pk(-90, 90, -90);
        model_frame(0, a_x, 1'b0, tmp0);
        q0.push_back(tmp0);
        model_frame(1, a_x, 1'b0, tmp1);
        q1.push_back(tmp1);
        v0 = n_valid0;
        o0 = n_ovr0;
        o1 = n_ovr1;
        @(negedge clk); drive(1'b1, a_x, 1'b0);
        repeat (2) @(negedge clk); drive(1'b0, a_x, 1'b0);
        repeat (2) @(negedge clk); drive(1'b1, b_x, 1'b0);
        repeat (25) @(negedge clk); drive(1'b0, b_x, 1'b0);
        repeat (3) @(negedge clk);
        chk("overrun_pulses0", n_ovr0 - o0, 1);
        chk("overrun_pulses1", n_ovr1 - o1, 1);
        chk("overrun_valids", n_valid0 - v0, 1);
        for (int i = 0; i < 3; i++) tick(a_x, 1'b0);

        // Reset asserted during S2 of ch1
        v0 = n_valid0;
        @(negedge clk); drive(1'b1, pk(120, -120, 60), 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_signal0", if0.o_signal, 0);
        chk("midrst_signal1", if1.o_signal, 0);
        chk("midrst_valid", if0.o_valid, 0);
        drive(1'b0, pk(120, -120, 60), 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_no_valid", n_valid0 - v0, 0);
        for (int i = 0; i < 20; i++) tick(pk(120, -120, 60), 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_drained0", q0.size(), 0);
        chk("queue_drained1", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
